// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bundle: ROM address/data port, decode delivery with stall, and redirect request.
// master = fetch unit side; slave = ROM/decode/branch side.
interface inst_fetch_unit_if;
   logic [29:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] fetch_count;

   modport master (
      output imem_addr, if_valid, if_inst, if_pc, fetch_count,
      input  imem_inst, stall, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_addr, if_valid, if_inst, if_pc, fetch_count,
      output imem_inst, stall, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end for a sync-read ROM: address presented in cycle t shows on if_* in t+1.
// stall holds the shown word (ROM re-reads it); redirects are delay-slot or squash per SQUASH_ON_REDIRECT.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC           = 32'h0000_0000,
   parameter bit          SQUASH_ON_REDIRECT = 1'b0
) (
   input logic               clk,
   input logic               rst,
   inst_fetch_unit_if.master bus
);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;

   localparam logic [29:0] RESET_WA = RESET_PC[31:2];

   state_t      r_st;
   logic [31:0] r_pc;
   logic        r_valid;
   logic        r_redir_pend;
   logic [29:0] r_redir_wa;
   logic [31:0] r_fetch_count;

   logic [29:0] w_nxt;
   logic        w_take_redir;
   logic        w_defer_redir;
   logic        w_take_pend;
   logic        w_squash;
   logic        w_if_valid;
   logic        w_unused_lsb;

   assign w_unused_lsb = &{1'b0, bus.redirect_pc[1:0]};

   assign w_squash   = SQUASH_ON_REDIRECT && bus.redirect_valid;
   assign w_if_valid = r_valid && !w_squash;

   // Next word address; first matching row wins.
   always_comb begin
      w_nxt         = r_pc[31:2] + 30'd1;
      w_take_redir  = 1'b0;
      w_defer_redir = 1'b0;
      w_take_pend   = 1'b0;
      if (rst || r_st == ST_BOOT) begin
         w_nxt = RESET_WA;
      end else if (bus.redirect_valid && (!bus.stall || SQUASH_ON_REDIRECT)) begin
         w_nxt        = bus.redirect_pc[31:2];
         w_take_redir = 1'b1;
      end else if (bus.redirect_valid) begin
         w_nxt         = r_pc[31:2];
         w_defer_redir = 1'b1;
      end else if (bus.stall) begin
         w_nxt = r_pc[31:2];
      end else if (r_redir_pend) begin
         w_nxt       = r_redir_wa;
         w_take_pend = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_st          <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_valid       <= 1'b0;
         r_redir_pend  <= 1'b0;
         r_redir_wa    <= 30'd0;
         r_fetch_count <= 32'd0;
      end else begin
         r_st    <= ST_RUN;
         r_pc    <= {w_nxt, 2'b00};
         r_valid <= 1'b1;
         if (w_take_redir || w_take_pend) begin
            r_redir_pend <= 1'b0;
         end else if (w_defer_redir) begin
            r_redir_pend <= 1'b1;
            r_redir_wa   <= bus.redirect_pc[31:2];
         end
         if (w_if_valid && !bus.stall) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   assign bus.imem_addr   = w_nxt;
   assign bus.if_valid    = !rst && w_if_valid;
   assign bus.if_inst     = bus.imem_inst;
   assign bus.if_pc       = rst ? RESET_PC : r_pc;
   assign bus.fetch_count = rst ? 32'd0 : r_fetch_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Two fetch units (delay-slot at 0x0, squash at 0x200) share stimulus; each is checked every cycle
// against a byte-address model of the fetch stream.
module tb_inst_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inst_fetch_unit_if bus0();
   inst_fetch_unit_if bus1();

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .SQUASH_ON_REDIRECT(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0.master));
   inst_fetch_unit #(.RESET_PC(32'h0000_0200), .SQUASH_ON_REDIRECT(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.master));

   // ROM: registers the word address, forced to 0 under reset; word n = 0x1000_0000 + n.
   logic [29:0] rom0_q, rom1_q;
   always @(posedge clk) begin
      rom0_q <= rst ? 30'd0 : bus0.imem_addr;
      rom1_q <= rst ? 30'd0 : bus1.imem_addr;
   end
   assign bus0.imem_inst = 32'h1000_0000 + {2'b00, rom0_q};
   assign bus1.imem_inst = 32'h1000_0000 + {2'b00, rom1_q};

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Model: what the lane shows now, and the address it will show next.
   logic [31:0] lane_rpc [2] = '{32'h0000_0000, 32'h0000_0200};
   logic        lane_sq  [2] = '{1'b0, 1'b1};
   logic        m_boot   [2];
   logic [31:0] m_pc     [2];
   logic [31:0] m_cnt    [2];
   logic        m_pend   [2];
   logic [31:0] m_tgt    [2];
   logic [31:0] n_pc     [2];
   logic        n_pend   [2];
   logic [31:0] n_tgt    [2];
   logic        n_cnt_inc[2];

   logic        cur_stall, cur_rv;
   logic [31:0] cur_rpc;

   task automatic check_lane(input int l, input logic [29:0] addr, input logic vld,
                             input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] cnt);
      logic        e_v;
      logic [31:0] e_next;
      logic [31:0] e_pc;
      logic [31:0] e_cnt;
      logic [31:0] wa;
      n_pend[l]    = m_pend[l];
      n_tgt[l]     = m_tgt[l];
      e_pc         = m_pc[l];
      e_cnt        = m_cnt[l];
      if (rst) begin
         e_v    = 1'b0;
         e_next = lane_rpc[l];
         e_pc   = lane_rpc[l];
         e_cnt  = 32'd0;
      end else if (m_boot[l]) begin
         e_v    = 1'b0;
         e_next = lane_rpc[l];
      end else begin
         e_v = !(lane_sq[l] && cur_rv);
         if (cur_rv && (!cur_stall || lane_sq[l])) begin
            e_next    = cur_rpc & ~32'd3;
            n_pend[l] = 1'b0;
         end else if (cur_rv) begin
            e_next    = m_pc[l];
            n_pend[l] = 1'b1;
            n_tgt[l]  = cur_rpc & ~32'd3;
         end else if (cur_stall) begin
            e_next = m_pc[l];
         end else if (m_pend[l]) begin
            e_next    = m_tgt[l];
            n_pend[l] = 1'b0;
         end else begin
            e_next = m_pc[l] + 32'd4;
         end
         wa = m_pc[l] >> 2;
         chk($sformatf("L%0d inst", l), inst, 32'h1000_0000 + wa);
      end
      n_pc[l]      = e_next;
      n_cnt_inc[l] = e_v && !cur_stall;
      wa = e_next >> 2;
      chk($sformatf("L%0d addr", l), {2'b00, addr}, wa);
      chk($sformatf("L%0d valid", l), {31'd0, vld}, {31'd0, e_v});
      chk($sformatf("L%0d pc", l), pc, e_pc);
      chk($sformatf("L%0d count", l), cnt, e_cnt);
   endtask

   task automatic advance_lane(input int l, input logic was_rst);
      if (was_rst) begin
         m_boot[l] = 1'b1;
         m_pc[l]   = lane_rpc[l];
         m_cnt[l]  = 32'd0;
         m_pend[l] = 1'b0;
         m_tgt[l]  = 32'd0;
      end else begin
         m_boot[l] = 1'b0;
         m_pc[l]   = n_pc[l];
         m_pend[l] = n_pend[l];
         m_tgt[l]  = n_tgt[l];
         if (n_cnt_inc[l]) m_cnt[l] = m_cnt[l] + 32'd1;
      end
   endtask

   task automatic step(input logic rst_i, input logic stall_i, input logic rv_i, input logic [31:0] rpc_i);
      logic was_rst;
      @(negedge clk);
      rst                 = rst_i;
      cur_stall           = stall_i;
      cur_rv              = rv_i;
      cur_rpc             = rpc_i;
      bus0.stall          = stall_i;
      bus1.stall          = stall_i;
      bus0.redirect_valid = rv_i;
      bus1.redirect_valid = rv_i;
      bus0.redirect_pc    = rpc_i;
      bus1.redirect_pc    = rpc_i;
      #1;
      check_lane(0, bus0.imem_addr, bus0.if_valid, bus0.if_pc, bus0.if_inst, bus0.fetch_count);
      check_lane(1, bus1.imem_addr, bus1.if_valid, bus1.if_pc, bus1.if_inst, bus1.fetch_count);
      was_rst = rst;
      @(posedge clk);
      advance_lane(0, was_rst);
      advance_lane(1, was_rst);
   endtask

   initial begin
      logic        r_i, s_i, v_i;
      logic [31:0] p_i;
      bus0.stall = 1'b0; bus1.stall = 1'b0;
      bus0.redirect_valid = 1'b0; bus1.redirect_valid = 1'b0;
      bus0.redirect_pc = 32'd0; bus1.redirect_pc = 32'd0;

      // reset, boot, sequential fetch
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      // stall hold, then release
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      // redirect with low bits set, no stall
      step(0, 0, 1, 32'h0000_02BF);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      // redirect under stall, stall held two more cycles
      step(0, 1, 1, 32'h0000_0100);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      // newer redirect overwrites a pending one
      step(0, 1, 1, 32'h0000_0800);
      step(0, 1, 1, 32'h0000_0040);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      // wrap at the top of the address space
      step(0, 0, 1, 32'hFFFF_FFFC);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      step(0, 0, 1, 32'hFFFF_FFF8);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      // reset with a redirect pending
      step(0, 1, 1, 32'h0000_0500);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

      for (int i = 0; i < 2000; i++) begin
         r_i = ($urandom_range(0, 99) == 0);
         s_i = ($urandom_range(0, 99) < 30);
         v_i = ($urandom_range(0, 99) < 15);
         p_i = $urandom;
         if ($urandom_range(0, 3) == 0) p_i = 32'hFFFF_FFF0 | {28'd0, p_i[3:0]};
         step(r_i, s_i, v_i, p_i);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
